// File: rtl/aes_shiftrows_pipe_if.sv
// Stream bundle for the ShiftRows engine: upstream block request plus downstream result and block count.
// master = traffic source/sink around the engine, slave = the engine itself.
interface aes_shiftrows_pipe_if #(
  parameter int NSHARES = 2,
  parameter int CNT_W   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_mode;
  logic [128*NSHARES-1:0]   in_state;
  logic                     out_valid;
  logic                     out_ready;
  logic [128*NSHARES-1:0]   out_state;
  logic                     out_err;
  logic [CNT_W-1:0]         blk_cnt;

  modport master (
    output in_valid, in_mode, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_err, blk_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_state, out_ready,
    output in_ready, out_valid, out_state, out_err, blk_cnt
  );
endinterface

// File: rtl/aes_shiftrows_pipe.sv
// Masked ShiftRows/InvShiftRows/bypass over NSHARES shares; LAT-cycle latency, 1 block/cycle.
// Elastic valid/ready pipeline: each stage refills when empty or draining; flush empties everything.
module aes_shiftrows_pipe #(
  parameter int NSHARES = 2,
  parameter int LAT     = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  aes_shiftrows_pipe_if.slave io
);
  localparam int W = 128 * NSHARES;

  logic [W-1:0]     perm_d;
  logic             err_d;
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   err_q;
  logic [W-1:0]     dat_q [LAT];
  logic [LAT-1:0]   load;
  logic [CNT_W-1:0] cnt_q;
  logic             out_fire;

  // Byte k of a share sits at row k%4, column k/4; each share is permuted on its own.
  always_comb begin
    perm_d = '0;
    for (int s = 0; s < NSHARES; s++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          case (io.in_mode)
            2'b00:   perm_d[128*s + 8*(r + 4*c) +: 8] = io.in_state[128*s + 8*(r + 4*((c + r) % 4)) +: 8];
            2'b01:   perm_d[128*s + 8*(r + 4*c) +: 8] = io.in_state[128*s + 8*(r + 4*((c - r + 4) % 4)) +: 8];
            default: perm_d[128*s + 8*(r + 4*c) +: 8] = io.in_state[128*s + 8*(r + 4*c) +: 8];
          endcase
        end
      end
    end
  end

  assign err_d = (io.in_mode == 2'b11);

  // Ready ripples backwards from the output: a stage can load if it is empty or its block leaves now.
  always_comb begin
    logic dn_rdy;
    dn_rdy = io.out_ready;
    load   = '0;
    for (int i = LAT - 1; i >= 0; i--) begin
      load[i] = !vld_q[i] || dn_rdy;
      dn_rdy  = load[i];
    end
  end

  assign io.in_ready = load[0] && !flush;
  assign out_fire    = vld_q[LAT-1] && io.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      if (out_fire) cnt_q <= cnt_q + 1'b1;
      // Data registers only move on a real transfer so idle bus values never land in the shares.
      if (load[0]) begin
        vld_q[0] <= io.in_valid;
        if (io.in_valid) begin
          err_q[0] <= err_d;
          dat_q[0] <= perm_d;
        end
      end
      for (int i = 1; i < LAT; i++) begin
        if (load[i]) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            err_q[i] <= err_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
    end
  end

  assign io.out_valid = vld_q[LAT-1];
  assign io.out_state = dat_q[LAT-1];
  assign io.out_err   = err_q[LAT-1];
  assign io.blk_cnt   = cnt_q;
endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench: two engine instances (masked LAT=2, unmasked LAT=3 with 4-bit counter) against a row-rotation model.
module tb_aes_shiftrows_pipe;
  logic clk;
  logic rst_n;
  logic flush_a;
  logic flush_b;
  int   checks   = 0;
  int   failures = 0;

  aes_shiftrows_pipe_if #(.NSHARES(2), .CNT_W(16)) ia ();
  aes_shiftrows_pipe_if #(.NSHARES(1), .CNT_W(4))  ib ();

  aes_shiftrows_pipe #(.NSHARES(2), .LAT(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .io(ia)
  );
  aes_shiftrows_pipe #(.NSHARES(1), .LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .io(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS-197 hex strings list byte 0 first; the bus keeps byte 0 in the low bits.
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = h[8*(15-k) +: 8];
    return o;
  endfunction

  // Reference: rotate each row r left (fwd) or right (inv) by r single-byte steps.
  function automatic logic [127:0] sr1(input logic [127:0] s, input logic [1:0] mode);
    logic [7:0] b [16];
    logic [7:0] row [4];
    logic [7:0] t;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = s[8*k +: 8];
    if (mode == 2'b00 || mode == 2'b01) begin
      for (int r = 1; r < 4; r++) begin
        for (int c = 0; c < 4; c++) row[c] = b[r + 4*c];
        for (int n = 0; n < r; n++) begin
          if (mode == 2'b00) begin
            t = row[0]; row[0] = row[1]; row[1] = row[2]; row[2] = row[3]; row[3] = t;
          end else begin
            t = row[3]; row[3] = row[2]; row[2] = row[1]; row[1] = row[0]; row[0] = t;
          end
        end
        for (int c = 0; c < 4; c++) b[r + 4*c] = row[c];
      end
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = b[k];
    return o;
  endfunction

  function automatic logic [255:0] sr2(input logic [255:0] s, input logic [1:0] mode);
    return {sr1(s[255:128], mode), sr1(s[127:0], mode)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    ia.in_valid = 0; ia.in_mode = 2'b00; ia.in_state = '0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_mode = 2'b00; ib.in_state = '0; ib.out_ready = 1;
    flush_a = 0; flush_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_err !== 1'b0 || ia.out_state !== '0 || ia.blk_cnt !== '0)
      begin failures++; $display("FAIL reset_outputs: valid=%b err=%b state=%h cnt=%0d, required all 0",
        ia.out_valid, ia.out_err, ia.out_state, ia.blk_cnt); end
    #2 rst_n = 1;
    @(negedge clk);
    checks++;
    if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_in_ready: a=%b b=%b, required 1", ia.in_ready, ib.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_vector();
    logic [127:0] vin, vout;
    vin  = fips(128'hd42711aee0bf98f1b8b45de51e415230);
    vout = fips(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    do_reset();
    ia.in_valid = 1; ia.in_mode = 2'b00; ia.in_state = {vin, vin};
    @(posedge clk); #1;
    ia.in_valid = 0; ia.in_state = '0;
    checks++;
    if (ia.out_valid !== 1'b0)
      begin failures++; $display("FAIL fwd_early_valid: got %b, required 0 one cycle after accept", ia.out_valid); end
    @(posedge clk); #1;
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_state !== {vout, vout} || ia.out_err !== 1'b0)
      begin failures++; $display("FAIL fwd_vector: valid=%b err=%b state=%h, required 1/0/%h",
        ia.out_valid, ia.out_err, ia.out_state, {vout, vout}); end
    @(posedge clk); #1;
    checks++;
    if (ia.blk_cnt !== 16'd1)
      begin failures++; $display("FAIL fwd_blk_cnt: got %0d, required 1", ia.blk_cnt); end
  endtask

  task automatic test_modes();
    logic [255:0] din  [4];
    logic [255:0] dexp [4];
    logic [1:0]   m    [4];
    logic         eexp [4];
    logic [127:0] a, b;
    a = fips(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    b = fips(128'hd42711aee0bf98f1b8b45de51e415230);
    din[0] = {a, a};                    m[0] = 2'b01; dexp[0] = {b, b};   eexp[0] = 0;
    din[1] = {rnd128(), rnd128()};      m[1] = 2'b10; dexp[1] = din[1];   eexp[1] = 0;
    din[2] = {rnd128(), rnd128()};      m[2] = 2'b11; dexp[2] = din[2];   eexp[2] = 1;
    din[3] = {rnd128(), rnd128()};      m[3] = 2'b00; dexp[3] = sr2(din[3], 2'b00); eexp[3] = 0;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin ia.in_valid = 1; ia.in_mode = m[j]; ia.in_state = din[j]; end
      else ia.in_valid = 0;
      @(posedge clk); #1;
      if (j >= 1) begin
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_state !== dexp[j-1] || ia.out_err !== eexp[j-1])
          begin failures++; $display("FAIL mode_blk%0d: valid=%b err=%b state=%h, required 1/%b/%h",
            j-1, ia.out_valid, ia.out_err, ia.out_state, eexp[j-1], dexp[j-1]); end
      end
    end
    ia.in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_masked();
    logic [127:0] s, r;
    logic [255:0] o;
    s = rnd128(); r = rnd128();
    do_reset();
    ia.in_valid = 1; ia.in_mode = 2'b00; ia.in_state = {s ^ r, r};
    @(posedge clk); #1;
    ia.in_valid = 0;
    @(posedge clk); #1;
    o = ia.out_state;
    checks++;
    if ((o[255:128] ^ o[127:0]) !== sr1(s, 2'b00))
      begin failures++; $display("FAIL masked_unmask: got %h, required %h", o[255:128] ^ o[127:0], sr1(s, 2'b00)); end
    checks++;
    if (o[127:0] !== sr1(r, 2'b00))
      begin failures++; $display("FAIL masked_share0: got %h, required %h", o[127:0], sr1(r, 2'b00)); end
  endtask

  task automatic test_back_to_back();
    logic [256:0] q [$];
    logic [256:0] e;
    logic [255:0] prev_dat;
    logic         prev_err;
    logic         prev_stall;
    logic         acc;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_dat = '0; prev_err = 0;
    do_reset();
    while (got < 100 && cyc < 3000) begin
      if (!ia.in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        ia.in_valid = 1;
        ia.in_mode  = 2'(sent % 4);
        ia.in_state = {rnd128(), rnd128()};
      end
      ia.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_state !== prev_dat || ia.out_err !== prev_err)
          begin failures++; $display("FAIL b2b_stall_stable: valid=%b err=%b state=%h, required 1/%b/%h",
            ia.out_valid, ia.out_err, ia.out_state, prev_err, prev_dat); end
      end
      if (ia.out_valid && ia.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 257'bx;
        checks++;
        if ({ia.out_err, ia.out_state} !== e)
          begin failures++; $display("FAIL b2b_blk%0d: err=%b state=%h, required %b/%h",
            got, ia.out_err, ia.out_state, e[256], e[255:0]); end
        got++;
      end
      prev_stall = ia.out_valid && !ia.out_ready;
      prev_dat   = ia.out_state;
      prev_err   = ia.out_err;
      acc = ia.in_valid && ia.in_ready;
      if (acc) begin
        q.push_back({ia.in_mode == 2'b11, sr2(ia.in_state, ia.in_mode)});
        sent++;
      end
      @(posedge clk); #1;
      if (acc) ia.in_valid = 0;
      cyc++;
    end
    checks++;
    if (got != 100)
      begin failures++; $display("FAIL b2b_timeout: got %0d blocks, required 100", got); end
    checks++;
    if (ia.blk_cnt !== 16'd100)
      begin failures++; $display("FAIL b2b_blk_cnt: got %0d, required 100", ia.blk_cnt); end
    ia.in_valid = 0; ia.out_ready = 1;
  endtask

  task automatic test_flush();
    int  n;
    logic seen;
    do_reset();
    ia.in_valid = 1; ia.in_mode = 2'b00; ia.in_state = {rnd128(), rnd128()};
    @(posedge clk); #1;
    ia.in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    ia.out_ready = 0; ia.in_valid = 1; ia.in_state = {rnd128(), rnd128()};
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ia.in_ready) break;
      @(posedge clk); #1;
      n++;
      ia.in_state = {rnd128(), rnd128()};
    end
    checks++;
    if (n != 2)
      begin failures++; $display("FAIL flush_fill: accepted %0d blocks under stall, required 2", n); end
    @(posedge clk); #1;
    flush_a = 1; ia.out_ready = 1;
    @(negedge clk);
    checks++;
    if (ia.in_ready !== 1'b0)
      begin failures++; $display("FAIL flush_in_ready: got %b, required 0", ia.in_ready); end
    @(posedge clk); #1;
    flush_a = 0; ia.in_valid = 0;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_state !== '0 || ia.out_err !== 1'b0 || ia.blk_cnt !== '0
        || dut_a.dat_q[0] !== '0)
      begin failures++; $display("FAIL flush_clear: valid=%b err=%b cnt=%0d state=%h stage0=%h, required all 0",
        ia.out_valid, ia.out_err, ia.blk_cnt, ia.out_state, dut_a.dat_q[0]); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ia.out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || ia.blk_cnt !== '0)
      begin failures++; $display("FAIL flush_stale: stale_valid=%b cnt=%0d, required 0/0", seen, ia.blk_cnt); end
  endtask

  task automatic test_wrap_and_async_reset();
    int sent, got, first;
    logic [127:0] last_exp;
    logic [127:0] q [$];
    logic seen;
    sent = 0; got = 0; first = -1; last_exp = '0;
    do_reset();
    for (int j = 0; j < 60 && got < 17; j++) begin
      if (sent < 17) begin
        ib.in_valid = 1; ib.in_mode = 2'($urandom_range(0, 2)); ib.in_state = rnd128();
      end else ib.in_valid = 0;
      @(negedge clk);
      if (ib.out_valid && ib.out_ready) begin
        if (got == 0) first = j;
        last_exp = (q.size() > 0) ? q.pop_front() : 128'bx;
        checks++;
        if (ib.out_state !== last_exp)
          begin failures++; $display("FAIL wrap_blk%0d: got %h, required %h", got, ib.out_state, last_exp); end
        got++;
      end
      if (ib.in_valid && ib.in_ready) begin q.push_back(sr1(ib.in_state, ib.in_mode)); sent++; end
      @(posedge clk); #1;
    end
    ib.in_valid = 0;
    checks++;
    if (first != 3)
      begin failures++; $display("FAIL lat3_first_out: first output in cycle %0d, required 3", first); end
    checks++;
    if (got != 17 || ib.blk_cnt !== 4'd1)
      begin failures++; $display("FAIL wrap_cnt: blocks=%0d cnt=%0d, required 17/1", got, ib.blk_cnt); end
    repeat (5) begin
      ib.in_valid = 1; ib.in_mode = 2'b00; ib.in_state = rnd128();
      @(posedge clk); #1;
    end
    checks++;
    if (ib.out_valid !== 1'b1)
      begin failures++; $display("FAIL midstream_valid: got %b, required 1 before reset", ib.out_valid); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (ib.out_valid !== 1'b0 || ib.out_state !== '0 || ib.blk_cnt !== '0 || ib.out_err !== 1'b0)
      begin failures++; $display("FAIL async_reset: valid=%b err=%b cnt=%0d state=%h, required all 0",
        ib.out_valid, ib.out_err, ib.blk_cnt, ib.out_state); end
    ib.in_valid = 0;
    #1 rst_n = 1;
    seen = 0;
    @(posedge clk); #1;
    repeat (6) begin
      @(negedge clk);
      if (ib.out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0)
      begin failures++; $display("FAIL reset_lost_blocks: output seen=%b, required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_fwd_vector();
    test_modes();
    test_masked();
    test_back_to_back();
    test_flush();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
